spi_frame_rx: RTL and testbench
===============================

// Module: spi_frame_rx
// PURPOSE
//  Parametrised SPI peripheral-side frame receiver; supersedes fixed 1+7+8-bit deserializer.
//  Oversamples SCLK/COPI/nCS in the clk domain; supports all four SPI modes (CPOL/CPHA).
//  Decodes frames as R/W bit + address + data words, with optional burst auto-increment.
//  Reports aborted frames. Drives one clk-wide write/read strobes into the register bank.
// PARAMETERS
//  ADDR_W       7  address field width (bits), >=1
//  DATA_W       8  data word width (bits), >=1
//  SYNC_STAGES  2  synchroniser flops per input, >=2
//  BURST_EN     1  1: each further DATA_W bits = next word at addr+1; 0: extra bits ignored
// PORTS
//  clk         in   1       system clock; must be >= 4x SCLK frequency
//  rst_n       in   1       reset, asynchronous, active-low
//  sclk        in   1       SPI clock pin, async to clk
//  copi        in   1       SPI data in pin, async
//  n_cs        in   1       SPI chip select pin, active-low, async
//  cpol        in   1       clock idle level; sampled only while in IDLE
//  cpha        in   1       0: sample leading edge, 1: trailing edge; sampled only in IDLE
//  read_write  out  1       R/W bit of current frame (1 = write)
//  addr        out  ADDR_W  word address for current strobe
//  data        out  DATA_W  received word, MSB first
//  valid       out  1       1-cycle strobe: addr/data/read_write coherent
//  frame_err   out  1       1-cycle strobe: frame ended with partial header/word
//  busy        out  1       high while state != IDLE
// BEHAVIOUR
//  Reset: read_write=0, addr=0, data=0, valid=0, frame_err=0, busy=0, state=IDLE,
//   bit counter=0; sclk sync chain -> 0; copi chain -> 0; n_cs chain -> 0 (asserted).
//   n_cs chain reset low => frame in progress at reset release never starts: a pin
//   high->low is required before any capture.
//  Sync: SYNC_STAGES flops each; one extra sclk flop for edge detect. copi/n_cs taken at
//   same depth as sclk edge detect, so data is aligned with the detected edge.
//  Sample edge: rising if cpol==cpha, else falling. cpol/cpha latched on IDLE->HDR.
//  States: IDLE -> HDR on n_cs_s fall; HDR -> DATA after 1+ADDR_W sample edges;
//   DATA -> DATA every DATA_W edges (BURST_EN=1) or DATA -> DONE (BURST_EN=0).
//   Any state -> IDLE when n_cs_s high (takes priority, same cycle).
//   DONE: edges ignored until n_cs_s high; no error raised.
//  Bit order: bit0 = R/W, then addr MSB..LSB, then data MSB..LSB.
//  Edges only counted while n_cs_s low; edge in same sync cycle as n_cs_s rise is ignored.
//  valid: registered; high exactly 1 clk, on the cycle after the edge completing a word.
//   Latency pin-edge -> valid = SYNC_STAGES+2 clk cycles.
//  Burst: addr for word k = base + k, modulo 2^ADDR_W (0x7F -> 0x00 at ADDR_W=7).
//   read_write constant for whole frame.
//  frame_err: 1-clk pulse when n_cs_s rises in HDR (any bits received) or in DATA
//   with 1..DATA_W-1 bits of current word. No valid for the partial word. Completed
//   words are kept. Rise in DATA at word boundary, or in DONE: no error.
//  n_cs fall with zero edges before its rise: no valid, no frame_err.
//  Outputs hold last values between strobes. Only valid/frame_err self-clear.
//  Async reset mid-frame aborts silently (no frame_err).
// TESTING
//  1 Mode 0, frame 1|0x2A|0xC3 -> one valid; rw=1, addr=0x2A, data=0xC3; no frame_err.
//  2 Mode 3 (cpol=1,cpha=1), frame 0|0x05|0x5A -> valid; rw=0, addr=0x05, data=0x5A.
//  3 BURST_EN=1, write at 0x7E, words 0x11,0x22,0x33 -> 3 valids.
//    addr 0x7E, 0x7F, 0x00; each valid exactly 1 clk.
//  4 n_cs raised after 5 bits -> frame_err 1 clk, no valid. Next full frame decodes.
//  5 rst_n pulsed after 9 bits; n_cs held low, edges continue -> no valid/frame_err.
//    Next frame (n_cs high then low) -> decodes.
//  6 BURST_EN=0, 1+7+8 bits then 8 extra edges -> single valid, no frame_err at n_cs rise.

Source files
------------

// File: rtl/spi_frame_rx_if.sv
// ----------------------------------------------------------------------------
// spi_frame_rx_if
//  Register-bank side bus of the SPI frame receiver. The receiver drives every
//  signal (master) and the register bank observes them (slave).
//  Signals:
//   read_write  R/W bit of the current frame (1 = write)
//   addr        word address belonging to the current strobe
//   data        received word, MSB first on the wire
//   valid       1-clk strobe: read_write/addr/data are coherent
//   frame_err   1-clk strobe: frame ended with a partial header or word
//   busy        receiver is not idle
// ----------------------------------------------------------------------------
interface spi_frame_rx_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) ();
  logic              read_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              frame_err;
  logic              busy;

  modport master (output read_write, addr, data, valid, frame_err, busy);
  modport slave  (input  read_write, addr, data, valid, frame_err, busy);
endinterface

// File: rtl/spi_frame_rx.sv
// ----------------------------------------------------------------------------
// spi_frame_rx
//  SPI peripheral-side frame receiver. SCLK, COPI and nCS are oversampled in
//  the clk domain, so clk must run at least 4x the SCLK frequency. All four SPI
//  modes are supported. A frame is one R/W bit, ADDR_W address bits and then
//  DATA_W-bit data words (MSB first). With BURST_EN each further word targets
//  the next address; otherwise bits after the first word are ignored.
//  Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   sclk_i       SPI clock pin (asynchronous)
//   copi_i       SPI data pin (asynchronous)
//   n_cs_i       SPI chip select pin, active-low (asynchronous)
//   cpol_i       clock idle level, taken when a frame starts
//   cpha_i       0: sample on leading edge, 1: trailing edge; taken at frame start
//   bus          register-bank bus (master side), see spi_frame_rx_if
// ----------------------------------------------------------------------------
module spi_frame_rx #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BURST_EN    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sclk_i,
  input  logic            copi_i,
  input  logic            n_cs_i,
  input  logic            cpol_i,
  input  logic            cpha_i,
  spi_frame_rx_if.master  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // The counter must hold values up to ADDR_W (header) and DATA_W-1 (word).
  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  // Synchronisers. The n_cs chain resets low so a chip select already low at
  // reset release never looks like a frame start: a real fall is required.
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, n_cs_sync_q;
  logic                   sclk_prev_q, n_cs_prev_q;
  logic                   sclk_s, copi_s, n_cs_s;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] hdr_sr_q, hdr_sr_d;
  logic [DATA_W-1:0] data_sr_q, data_sr_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic              rw_frame_q, rw_frame_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;

  // Completed word waiting one cycle to be published with its strobe.
  logic              word_done_q, word_done_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [DATA_W-1:0] word_data_q, word_data_d;

  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;

  logic              rise, fall, sample_edge;
  logic [ADDR_W:0]   hdr_next;
  logic [DATA_W:0]   data_next;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign n_cs_s = n_cs_sync_q[SYNC_STAGES-1];

  assign rise = sclk_s & ~sclk_prev_q;
  assign fall = ~sclk_s & sclk_prev_q;
  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  assign sample_edge = (cpol_q == cpha_q) ? rise : fall;

  // Shift registers with the incoming bit appended; the top bit is the oldest.
  assign hdr_next  = {hdr_sr_q, copi_s};
  assign data_next = {data_sr_q, copi_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    hdr_sr_d    = hdr_sr_q;
    data_sr_d   = data_sr_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    rw_frame_d  = rw_frame_q;
    addr_cnt_d  = addr_cnt_q;
    word_done_d = 1'b0;
    word_addr_d = word_addr_q;
    word_data_d = word_data_q;
    frame_err_d = 1'b0;

    if (n_cs_s) begin
      // Deselect wins over any edge seen in the same cycle.
      if ((state_q == ST_HDR || state_q == ST_DATA) && bit_cnt_q != '0) begin
        frame_err_d = 1'b1;
      end
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (n_cs_prev_q) begin
            state_d   = ST_HDR;
            bit_cnt_d = '0;
            cpol_d    = cpol_i;
            cpha_d    = cpha_i;
          end
        end
        ST_HDR: begin
          if (sample_edge) begin
            if (bit_cnt_q == CNT_W'(ADDR_W)) begin
              rw_frame_d = hdr_next[ADDR_W];
              addr_cnt_d = hdr_next[ADDR_W-1:0];
              bit_cnt_d  = '0;
              state_d    = ST_DATA;
            end else begin
              hdr_sr_d  = hdr_next[ADDR_W-1:0];
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (sample_edge) begin
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              word_done_d = 1'b1;
              word_data_d = data_next[DATA_W-1:0];
              word_addr_d = addr_cnt_q;
              addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
              bit_cnt_d   = '0;
              if (BURST_EN == 0) begin
                state_d = ST_DONE;
              end
            end else begin
              data_sr_d = data_next[DATA_W-1:0];
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          // ST_DONE: swallow edges until deselect.
        end
      endcase
    end
  end

  // Output stage: a completed word is published even if deselect arrives in
  // the same cycle, so words finished before an abort are never lost.
  always_comb begin
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = word_done_q;
    if (word_done_q) begin
      rw_d   = rw_frame_q;
      addr_d = word_addr_q;
      data_d = word_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      n_cs_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      n_cs_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      hdr_sr_q    <= '0;
      data_sr_q   <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      rw_frame_q  <= 1'b0;
      addr_cnt_q  <= '0;
      word_done_q <= 1'b0;
      word_addr_q <= '0;
      word_data_q <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_i};
      n_cs_sync_q <= {n_cs_sync_q[SYNC_STAGES-2:0], n_cs_i};
      sclk_prev_q <= sclk_s;
      n_cs_prev_q <= n_cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hdr_sr_q    <= hdr_sr_d;
      data_sr_q   <= data_sr_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      rw_frame_q  <= rw_frame_d;
      addr_cnt_q  <= addr_cnt_d;
      word_done_q <= word_done_d;
      word_addr_q <= word_addr_d;
      word_data_q <= word_data_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.read_write = rw_q;
  assign bus.addr       = addr_q;
  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_spi_frame_rx
//  Directed bench for spi_frame_rx. Instance A runs with burst enabled,
//  instance B with burst disabled; both share SCLK/COPI/CPOL/CPHA but each has
//  its own chip select. Monitors log every valid cycle and count frame_err
//  cycles; each test checks the deltas against hand-computed values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_frame_rx;

  localparam int HALF = 4;  // clk cycles per SCLK half-period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0, copi = 1'b0, n_cs_a = 1'b1, n_cs_b = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_frame_rx_if #(.ADDR_W(7), .DATA_W(8)) bus_a ();
  spi_frame_rx_if #(.ADDR_W(7), .DATA_W(8)) bus_b ();

  spi_frame_rx #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2), .BURST_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .copi_i(copi), .n_cs_i(n_cs_a),
    .cpol_i(cpol), .cpha_i(cpha), .bus(bus_a)
  );

  spi_frame_rx #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2), .BURST_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .copi_i(copi), .n_cs_i(n_cs_b),
    .cpol_i(cpol), .cpha_i(cpha), .bus(bus_b)
  );

  // Monitors: every valid-high cycle is logged, so a strobe wider than one
  // clk shows up as an extra entry.
  logic       log_rw_a   [0:63];
  logic [6:0] log_addr_a [0:63];
  logic [7:0] log_data_a [0:63];
  int nv_a = 0, ne_a = 0;
  logic       log_rw_b   [0:63];
  logic [6:0] log_addr_b [0:63];
  logic [7:0] log_data_b [0:63];
  int nv_b = 0, ne_b = 0;

  always @(negedge clk) begin
    if (bus_a.valid === 1'b1) begin
      if (nv_a < 64) begin
        log_rw_a[nv_a]   = bus_a.read_write;
        log_addr_a[nv_a] = bus_a.addr;
        log_data_a[nv_a] = bus_a.data;
      end
      nv_a = nv_a + 1;
    end
    if (bus_a.frame_err === 1'b1) ne_a = ne_a + 1;
  end

  always @(negedge clk) begin
    if (bus_b.valid === 1'b1) begin
      if (nv_b < 64) begin
        log_rw_b[nv_b]   = bus_b.read_write;
        log_addr_b[nv_b] = bus_b.addr;
        log_data_b[nv_b] = bus_b.data;
      end
      nv_b = nv_b + 1;
    end
    if (bus_b.frame_err === 1'b1) ne_b = ne_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low(input bit sel_b, input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    wait_clk(6);
    if (sel_b) n_cs_b = 1'b0; else n_cs_a = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high(input bit sel_b);
    wait_clk(HALF);
    if (sel_b) n_cs_b = 1'b1; else n_cs_a = 1'b1;
    wait_clk(10);
  endtask

  // Sends bits[n-1:0] MSB first using the current cpol/cpha.
  task automatic clock_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        copi = bits[i];
        wait_clk(HALF);
        sclk = ~cpol;
        wait_clk(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        copi = bits[i];
        wait_clk(HALF);
        sclk = cpol;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic frame_a(input logic pol, input logic pha, input logic [63:0] bits, input int n);
    cs_low(1'b0, pol, pha);
    clock_bits(bits, n);
    cs_high(1'b0);
  endtask

  initial begin
    int v0, e0;
    logic [15:0] f5;
    logic [1:0]  modes [0:1];
    logic [15:0] mframes [0:1];
    modes[0] = 2'b01; mframes[0] = {1'b0, 7'h55, 8'h3C};  // cpol=0 cpha=1
    modes[1] = 2'b10; mframes[1] = {1'b1, 7'h01, 8'h80};  // cpol=1 cpha=0

    wait_clk(3);
    // Reset state
    check("rst_valid", bus_a.valid, 0);
    check("rst_ferr", bus_a.frame_err, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_rw", bus_a.read_write, 0);
    check("rst_addr", bus_a.addr, 0);
    check("rst_data", bus_a.data, 0);
    rst_n = 1'b1;
    wait_clk(10);
    check("post_rst_ferr_cnt", ne_a, 0);

    // T1: mode 0, 1|0x2A|0xC3
    v0 = nv_a; e0 = ne_a;
    cs_low(1'b0, 1'b0, 1'b0);
    clock_bits(64'h0000_0000_0000_0002, 2);  // first bits 1,0 of 0xAAC3
    check("t1_busy", bus_a.busy, 1);
    clock_bits(64'h0000_0000_0000_2AC3, 14);
    cs_high(1'b0);
    check("t1_nvalid", nv_a - v0, 1);
    check("t1_rw", log_rw_a[v0], 1);
    check("t1_addr", log_addr_a[v0], 7'h2A);
    check("t1_data", log_data_a[v0], 8'hC3);
    check("t1_ferr", ne_a - e0, 0);
    check("t1_idle", bus_a.busy, 0);
    check("t1_hold_data", bus_a.data, 8'hC3);

    // T2: mode 3, 0|0x05|0x5A
    v0 = nv_a; e0 = ne_a;
    frame_a(1'b1, 1'b1, {48'h0, 1'b0, 7'h05, 8'h5A}, 16);
    check("t2_nvalid", nv_a - v0, 1);
    check("t2_rw", log_rw_a[v0], 0);
    check("t2_addr", log_addr_a[v0], 7'h05);
    check("t2_data", log_data_a[v0], 8'h5A);
    check("t2_ferr", ne_a - e0, 0);

    // Modes 1 and 2
    for (int m = 0; m < 2; m++) begin
      v0 = nv_a;
      frame_a(modes[m][1], modes[m][0], {48'h0, mframes[m]}, 16);
      check("mode_nvalid", nv_a - v0, 1);
      check("mode_rw", log_rw_a[v0], mframes[m][15]);
      check("mode_addr", log_addr_a[v0], mframes[m][14:8]);
      check("mode_data", log_data_a[v0], mframes[m][7:0]);
    end

    // T3: burst write at 0x7E, three words, address wraps
    v0 = nv_a; e0 = ne_a;
    frame_a(1'b0, 1'b0, {32'h0, 1'b1, 7'h7E, 8'h11, 8'h22, 8'h33}, 32);
    check("t3_nvalid", nv_a - v0, 3);
    check("t3_addr0", log_addr_a[v0], 7'h7E);
    check("t3_addr1", log_addr_a[v0+1], 7'h7F);
    check("t3_addr2", log_addr_a[v0+2], 7'h00);
    check("t3_data0", log_data_a[v0], 8'h11);
    check("t3_data1", log_data_a[v0+1], 8'h22);
    check("t3_data2", log_data_a[v0+2], 8'h33);
    check("t3_rw", {log_rw_a[v0], log_rw_a[v0+1], log_rw_a[v0+2]}, 3'b111);
    check("t3_ferr", ne_a - e0, 0);

    // T4: abort after 5 header bits, then a clean frame
    v0 = nv_a; e0 = ne_a;
    frame_a(1'b0, 1'b0, 64'h0000_0000_0000_0015, 5);
    check("t4_ferr", ne_a - e0, 1);
    check("t4_nvalid", nv_a - v0, 0);
    v0 = nv_a; e0 = ne_a;
    frame_a(1'b0, 1'b0, {48'h0, 1'b0, 7'h11, 8'hA5}, 16);
    check("t4b_nvalid", nv_a - v0, 1);
    check("t4b_addr", log_addr_a[v0], 7'h11);
    check("t4b_data", log_data_a[v0], 8'hA5);
    check("t4b_ferr", ne_a - e0, 0);

    // T4c: abort mid data word -> error, completed burst words kept
    v0 = nv_a; e0 = ne_a;
    frame_a(1'b0, 1'b0, {40'h0, 1'b1, 7'h20, 8'h9C, 3'b101, 5'h0} >> 5, 19);
    check("t4c_ferr", ne_a - e0, 1);
    check("t4c_nvalid", nv_a - v0, 1);
    check("t4c_data", log_data_a[v0], 8'h9C);

    // T5: reset pulse after 9 bits while n_cs stays low
    f5 = {1'b1, 7'h33, 8'h96};
    v0 = nv_a; e0 = ne_a;
    cs_low(1'b0, 1'b0, 1'b0);
    clock_bits({55'h0, f5[15:7]}, 9);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    clock_bits({57'h0, f5[6:0]}, 7);
    check("t5_busy", bus_a.busy, 0);
    cs_high(1'b0);
    check("t5_nvalid", nv_a - v0, 0);
    check("t5_ferr", ne_a - e0, 0);
    v0 = nv_a;
    frame_a(1'b0, 1'b0, {48'h0, 1'b1, 7'h40, 8'h0F}, 16);
    check("t5b_nvalid", nv_a - v0, 1);
    check("t5b_addr", log_addr_a[v0], 7'h40);
    check("t5b_data", log_data_a[v0], 8'h0F);

    // T6: burst disabled, 8 extra edges ignored, no error
    v0 = nv_b; e0 = ne_b;
    cs_low(1'b1, 1'b0, 1'b0);
    clock_bits({40'h0, 1'b1, 7'h2C, 8'hE7, 8'hFF}, 24);
    check("t6_busy", bus_b.busy, 1);
    cs_high(1'b1);
    check("t6_nvalid", nv_b - v0, 1);
    check("t6_rw", log_rw_b[v0], 1);
    check("t6_addr", log_addr_b[v0], 7'h2C);
    check("t6_data", log_data_b[v0], 8'hE7);
    check("t6_ferr", ne_b - e0, 0);
    check("t6_idle", bus_b.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
